// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constant helpers for the uart transmit path: state encoding,
// clog2 and the frame timing arithmetic used by the arbiter and uart controllers.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HOLD = 2'd2
   } arb_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((64'(1) << width) < 64'(value)) width++;
      return width;
   endfunction

   // Index width that never collapses to zero bits for a single requester.
   function automatic int unsigned id_width(input int unsigned req);
      return (req > 1) ? clog2(req) : 1;
   endfunction

   function automatic int unsigned clks_per_bit(input int unsigned clock_freq_hz,
                                                input int unsigned baud_rate);
      return clock_freq_hz / baud_rate;
   endfunction

   function automatic int unsigned frame_cycles(input int unsigned bit_width,
                                                input int unsigned cpb,
                                                input int unsigned guard);
      return bit_width * cpb + guard;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo REQ.
module rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter  int unsigned REQ = 2,
   localparam int unsigned IDW = id_width(REQ)
) (
   input  logic [REQ-1:0] req,
   input  logic [IDW-1:0] ptr,
   output logic           any,
   output logic [IDW-1:0] idx
);

   logic [IDW-1:0] cand;

   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int unsigned off = 0; off < REQ; off++) begin
         cand = IDW'((32'(ptr) + off) % REQ);
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter between REQ byte producers;
// frames are paced by an internal timer since the uart exposes no busy flag.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter  int unsigned REQ           = 2,
   parameter  int unsigned BIT_WIDTH     = 11,
   parameter  int unsigned BAUD_RATE     = 230400,
   parameter  int unsigned CLOCK_FREQ_HZ = 100000000,
   parameter  int unsigned GUARD_CYCLES  = 2,
   localparam int unsigned IDW           = id_width(REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REQ-1:0]   req_valid,
   input  logic [8*REQ-1:0] req_data,
   output logic [REQ-1:0]   req_ack,
   output logic             send,
   output logic [7:0]       tx_data,
   output logic [IDW-1:0]   grant_id,
   output logic             busy
);

   localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ_HZ, BAUD_RATE);
   localparam int unsigned FRAME_CYCLES = frame_cycles(BIT_WIDTH, CLKS_PER_BIT, GUARD_CYCLES);
   localparam int unsigned CNT_W        = clog2(FRAME_CYCLES + 1);
   localparam int unsigned SEL_W        = clog2(8 * REQ);

   arb_state_e       state_q;
   arb_state_e       state_d;
   logic [IDW-1:0]   ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             pick_any;
   logic [IDW-1:0]   pick_idx;
   logic             take;
   logic             send_d;
   logic             busy_d;
   logic [REQ-1:0]   ack_d;
   logic [SEL_W-1:0] byte_lsb;

   rr_pick #(.REQ(REQ)) u_rr_pick (
      .req (req_valid),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   // Requests are only looked at in IDLE, so late deassertion cannot recapture.
   assign take     = (state_q == IDLE) && pick_any;
   assign byte_lsb = SEL_W'(32'(pick_idx) * 8);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any) state_d = SEND;
         SEND:    state_d = HOLD;
         HOLD:    if (cnt_q == CNT_W'(1)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs, derived from the upcoming state.
   always_comb begin
      send_d = (state_d == SEND);
      busy_d = (state_d != IDLE);
      ack_d  = '0;
      if (take) ack_d[pick_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         send     <= 1'b0;
         req_ack  <= '0;
         busy     <= 1'b0;
         tx_data  <= 8'h00;
         grant_id <= '0;
         ptr_q    <= '0;
         cnt_q    <= '0;
      end else begin
         send    <= send_d;
         req_ack <= ack_d;
         busy    <= busy_d;
         if (take) begin
            tx_data  <= req_data[byte_lsb +: 8];
            grant_id <= pick_idx;
            ptr_q    <= (32'(pick_idx) == REQ - 1) ? '0 : pick_idx + IDW'(1);
            cnt_q    <= CNT_W'(FRAME_CYCLES);
         end else if (state_q == HOLD) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter at REQ=3 with a 44-cycle frame, plus an
// exhaustive sweep of the rr_pick selector.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  req_valid;
   logic [23:0] req_data;
   logic [2:0]  req_ack;
   logic        send;
   logic [7:0]  tx_data;
   logic [1:0]  grant_id;
   logic        busy;

   logic [2:0]  pk_req;
   logic [1:0]  pk_ptr;
   logic        pk_any;
   logic [1:0]  pk_idx;

   int n_checks = 0;
   int n_fail   = 0;

   int          times[6];
   logic [7:0]  seq[6];
   logic [2:0]  acks[6];

   uart_tx_arbiter #(
      .REQ(3), .BIT_WIDTH(11), .BAUD_RATE(10), .CLOCK_FREQ_HZ(40), .GUARD_CYCLES(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ack(req_ack), .send(send), .tx_data(tx_data), .grant_id(grant_id), .busy(busy)
   );

   rr_pick #(.REQ(3)) u_pick (.req(pk_req), .ptr(pk_ptr), .any(pk_any), .idx(pk_idx));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_idle_timeout: busy=%b expected 0", tag, busy);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 3'b000; req_data = 24'h0;
      @(posedge clk); @(negedge clk);
      n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL reset_send: got %b expected 0", send); end
      n_checks++; if (req_ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b expected 000", req_ack); end
      n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
      n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || send !== 1'b0) begin n_fail++; $display("FAIL release_idle: busy=%b send=%b expected 0 0", busy, send); end
   endtask

   task automatic test_single_byte();
      int cnt;
      req_valid = 3'b010; req_data = {8'h00, 8'h41, 8'h00};
      @(negedge clk);
      n_checks++; if (send !== 1'b1) begin n_fail++; $display("FAIL single_send: got %b expected 1", send); end
      n_checks++; if (req_ack !== 3'b010) begin n_fail++; $display("FAIL single_ack: got %b expected 010", req_ack); end
      n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_tx_data: got %h expected 41", tx_data); end
      n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL single_grant: got %0d expected 1", grant_id); end
      req_valid = 3'b000;
      cnt = busy ? 1 : 0;
      @(negedge clk);
      n_checks++; if (send !== 1'b0 || req_ack !== 3'b000) begin n_fail++; $display("FAIL single_pulse_width: send=%b ack=%b expected 0 000", send, req_ack); end
      while (busy && cnt < 100) begin cnt++; @(negedge clk); end
      n_checks++; if (cnt != 45) begin n_fail++; $display("FAIL single_busy_len: got %0d expected 45", cnt); end
      n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_tx_hold: got %h expected 41", tx_data); end
   endtask

   task automatic test_wrap_skip();
      req_valid = 3'b001; req_data = {8'hA2, 8'hA1, 8'hA0};
      @(negedge clk);
      n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL wrap_grant: got %0d expected 0", grant_id); end
      n_checks++; if (req_ack !== 3'b001) begin n_fail++; $display("FAIL wrap_ack: got %b expected 001", req_ack); end
      n_checks++; if (tx_data !== 8'hA0) begin n_fail++; $display("FAIL wrap_tx_data: got %h expected a0", tx_data); end
      req_valid = 3'b000;
      wait_idle("wrap");
      req_valid = 3'b111;
      @(negedge clk);
      n_checks++; if (grant_id !== 2'd1) begin n_fail++; $display("FAIL skip_grant: got %0d expected 1", grant_id); end
      n_checks++; if (req_ack !== 3'b010) begin n_fail++; $display("FAIL skip_ack: got %b expected 010", req_ack); end
      n_checks++; if (tx_data !== 8'hA1) begin n_fail++; $display("FAIL skip_tx_data: got %h expected a1", tx_data); end
      req_valid = 3'b000;
      wait_idle("skip");
   endtask

   task automatic test_fairness();
      int nsend, cyc;
      logic [7:0] exp_byte;
      logic [2:0] exp_ack;
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
      req_valid = 3'b111; req_data = {8'h33, 8'h32, 8'h31};
      nsend = 0; cyc = 0;
      while (nsend < 6 && cyc < 400) begin
         @(negedge clk); cyc++;
         if (send) begin
            times[nsend] = cyc; seq[nsend] = tx_data; acks[nsend] = req_ack; nsend++;
         end
      end
      req_valid = 3'b000;
      n_checks++; if (nsend != 6) begin n_fail++; $display("FAIL fair_count: got %0d sends expected 6", nsend); end
      for (int k = 0; k < nsend; k++) begin
         exp_byte = 8'h31 + 8'(k % 3);
         exp_ack  = 3'b001 << (k % 3);
         n_checks++; if (seq[k] !== exp_byte) begin n_fail++; $display("FAIL fair_tx_data[%0d]: got %h expected %h", k, seq[k], exp_byte); end
         n_checks++; if (acks[k] !== exp_ack) begin n_fail++; $display("FAIL fair_ack[%0d]: got %b expected %b", k, acks[k], exp_ack); end
         if (k > 0) begin
            n_checks++; if (times[k] - times[k-1] != 46) begin n_fail++; $display("FAIL fair_spacing[%0d]: got %0d expected 46", k, times[k] - times[k-1]); end
         end
      end
      wait_idle("fair");
   endtask

   task automatic test_late_drop();
      int nack, nsend, since;
      req_valid = 3'b001; req_data = {8'h00, 8'h00, 8'h55};
      nack = 0; nsend = 0; since = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (req_ack[0]) nack++;
         if (send) nsend++;
         if (nack > 0) begin
            since++;
            if (since > 10) req_valid = 3'b000;
         end
      end
      n_checks++; if (nack != 1) begin n_fail++; $display("FAIL late_ack_count: got %0d expected 1", nack); end
      n_checks++; if (nsend != 1) begin n_fail++; $display("FAIL late_send_count: got %0d expected 1", nsend); end
      n_checks++; if (tx_data !== 8'h55) begin n_fail++; $display("FAIL late_tx_data: got %h expected 55", tx_data); end
      wait_idle("late");
   endtask

   task automatic test_reset_mid_frame();
      req_valid = 3'b001; req_data = {8'h00, 8'h00, 8'h77};
      @(negedge clk);
      n_checks++; if (send !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL midrst_setup: send=%b grant=%0d expected 1 0", send, grant_id); end
      req_valid = 3'b000;
      repeat (5) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_in_hold: busy=%b expected 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_async: got %b expected 0", busy); end
      n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL midrst_send_async: got %b expected 0", send); end
      n_checks++; if (tx_data !== 8'h00 || grant_id !== 2'd0) begin n_fail++; $display("FAIL midrst_regs: tx=%h grant=%0d expected 00 0", tx_data, grant_id); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: busy=%b expected 0", busy); end
      req_valid = 3'b011; req_data = {8'h00, 8'h62, 8'h61};
      @(negedge clk);
      n_checks++; if (send !== 1'b1) begin n_fail++; $display("FAIL midrst_resume_send: got %b expected 1", send); end
      n_checks++; if (grant_id !== 2'd0 || tx_data !== 8'h61) begin n_fail++; $display("FAIL midrst_ptr_cleared: grant=%0d tx=%h expected 0 61", grant_id, tx_data); end
      req_valid = 3'b000;
      wait_idle("midrst");
   endtask

   task automatic test_rr_pick();
      logic [5:0] dbl;
      logic [2:0] r;
      int pos;
      logic       exp_any;
      logic [1:0] exp_idx;
      for (int rv = 0; rv < 8; rv++) begin
         for (int p = 0; p < 3; p++) begin
            r = 3'(rv);
            pk_req = r; pk_ptr = 2'(p);
            #1;
            dbl = {r, r} >> p;
            exp_any = |r;
            pos = 0;
            for (int b = 2; b >= 0; b--) if (dbl[b]) pos = b;
            exp_idx = 2'((p + pos) % 3);
            n_checks++; if (pk_any !== exp_any) begin n_fail++; $display("FAIL rr_any req=%b ptr=%0d: got %b expected %b", r, p, pk_any, exp_any); end
            if (exp_any) begin
               n_checks++; if (pk_idx !== exp_idx) begin n_fail++; $display("FAIL rr_idx req=%b ptr=%0d: got %0d expected %0d", r, p, pk_idx, exp_idx); end
            end
         end
      end
   endtask

   initial begin
      pk_req = 3'b000; pk_ptr = 2'd0;
      test_reset();
      test_single_byte();
      test_wrap_skip();
      test_fairness();
      test_late_drop();
      test_reset_mid_frame();
      test_rr_pick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
